bullet_hit_scanner: RTL and testbench
=====================================

BULLET_HIT_SCANNER -- requirements
Module: bullet_hit_scanner

Interface
REQ-001 SHALL have parameter N_BULLETS, default 20, number of bullet slots scanned.
REQ-002 SHALL have parameter HALF_W, default 10'd16, player hit-box half width in pixels.
REQ-003 SHALL have parameter HALF_H, default 10'd16, player hit-box half height in pixels.
REQ-004 SHALL have ports:
  Clk  input  1  single system clock; all state on rising edge.
  Reset_n  input  1  asynchronous, active-low reset.
  frame_start  input  1  single-cycle pulse requesting one scan per frame.
  player_x, player_y  input  10 each  player hit-box centre.
  bullet_x, bullet_y  input  10 x N_BULLETS each  bullet positions.
  bullet_state  input  2 x N_BULLETS  00 idle, 01/10 active, 11 exploding.
  hit  output  N_BULLETS  per-bullet new-hit flags, consumed by the health bar.
  hit_count  output  5  number of set bits in hit.
  hit_valid  output  1  one-cycle pulse when hit/hit_count update.
  busy  output  1  high while a scan is in progress.
  overrun  output  1  sticky flag: frame_start arrived while busy.

Function
REQ-005 SHALL implement FSM states IDLE, SCAN, PUBLISH.
REQ-006 IDLE: on frame_start=1, SHALL latch player_x/player_y into internal registers, clear index to 0, clear the scratch hit vector, go to SCAN.
REQ-007 SCAN: SHALL evaluate exactly one bullet per cycle, in order index 0..N_BULLETS-1, using live bullet_x/y/state[index] and the latched player position.
REQ-008 A bullet SHALL be a candidate when bullet_state is 01 or 10 and it lies inside the box, inclusive on all edges.
REQ-009 Box test SHALL be computed in 11-bit unsigned arithmetic without subtraction: bx+HALF_W >= px, bx <= px+HALF_W, by+HALF_H >= py, by <= py+HALF_H. No wrap at 0 or 1023.
REQ-010 Per bullet, the block SHALL keep a mask bit. A candidate whose mask bit is 0 SHALL set its scratch hit bit and set its mask bit. A candidate whose mask bit is 1 SHALL be ignored.
REQ-011 When the scanned bullet_state is 00, the block SHALL clear that bullet's mask bit.
REQ-012 After evaluating index N_BULLETS-1, the FSM SHALL go to PUBLISH.
REQ-013 PUBLISH, lasting one cycle: SHALL load hit from the scratch vector, load hit_count with its popcount (0..20), assert hit_valid for that cycle, then return to IDLE.
REQ-014 Latency: with frame_start sampled at edge 0, SCAN SHALL occupy edges 1..N_BULLETS, and hit/hit_count/hit_valid SHALL be visible after edge N_BULLETS+1 (edge 21 for default).
REQ-015 hit and hit_count SHALL hold their value until the next PUBLISH, with no clearing in between.
REQ-016 busy SHALL be 1 in SCAN and PUBLISH, and 0 in IDLE.
REQ-017 frame_start while busy SHALL be ignored: it SHALL NOT restart or extend the scan, and it SHALL set overrun, which stays 1 until reset.
REQ-018 frame_start arriving in the same cycle as the PUBLISH-to-IDLE transition counts as busy, so REQ-017 applies.
REQ-019 Player position changes during SCAN SHALL have no effect on the scan in progress.
REQ-020 Each bullet SHALL be reported at most once per active lifetime, even if it stays in the box across many frames.

Reset
REQ-021 Reset_n=0 SHALL asynchronously force: state IDLE, index 0, hit 0, hit_count 0, hit_valid 0, busy 0, overrun 0, all mask bits 0, scratch 0.
REQ-022 Reset asserted mid-SCAN SHALL abort the scan with no PUBLISH.
REQ-023 After Reset_n deasserts, the block SHALL accept frame_start on the first following edge.

Verification
REQ-024 Single hit: player (100,100), bullet 3 at (116,84) state 01, all others idle; pulse frame_start -> after edge 21, hit=20'h00008, hit_count=1, hit_valid high for one cycle.
REQ-025 Edge exclusion: bullet 0 at (117,100) and bullet 1 at (100,83), both state 10 -> hit=0, hit_count=0, hit_valid still pulses.
REQ-026 Mask behaviour:
  - Bullet 5 stays inside the box, state 01, for 3 frames -> hit bit 5 is 1 in frame 1 only.
  - Set state 00 for one frame, then 01 again -> bit 5 is reported again.
REQ-027 Near-zero origin: player (5,5), bullet 7 at (0,0) state 01 -> hit bit 7=1, with no underflow miss.
REQ-028 Overrun: second frame_start 10 cycles after the first -> still one hit_valid at edge 21, overrun=1 and stays 1. Pulse Reset_n -> overrun=0.
REQ-029 Reset mid-scan: assert Reset_n=0 at edge 12 of a scan in which bullet 2 would hit -> no hit_valid, hit=0, busy=0 immediately. After release, the next scan reports bit 2, because its mask was cleared.

Source files
------------

// File: rtl/bullet_hit_scanner.sv
// Per-frame bullet/player collision scanner: one bullet slot per cycle, then a
// one-cycle publish of newly-hit bullets. A per-slot mask reports each bullet once per lifetime.
module bullet_hit_scanner #(
  parameter int unsigned N_BULLETS = 20,
  parameter logic [9:0]  HALF_W    = 10'd16,
  parameter logic [9:0]  HALF_H    = 10'd16
) (
  input  logic                      Clk,
  input  logic                      Reset_n,
  input  logic                      frame_start,
  input  logic [9:0]                player_x,
  input  logic [9:0]                player_y,
  input  logic [10*N_BULLETS-1:0]   bullet_x,
  input  logic [10*N_BULLETS-1:0]   bullet_y,
  input  logic [2*N_BULLETS-1:0]    bullet_state,
  output logic [N_BULLETS-1:0]      hit,
  output logic [4:0]                hit_count,
  output logic                      hit_valid,
  output logic                      busy,
  output logic                      overrun
);

  localparam int unsigned IDXW = (N_BULLETS > 1) ? $clog2(N_BULLETS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, PUBLISH} state_t;

  state_t               state, state_nxt;
  logic [IDXW-1:0]      idx;
  logic [9:0]           px_q, py_q;
  logic [N_BULLETS-1:0] mask, scratch;
  logic [9:0]           cur_x, cur_y;
  logic [1:0]           cur_st;
  logic                 in_box, active, candidate, last;
  logic [4:0]           pop;

  always_comb begin
    cur_x  = bullet_x[int'(idx)*10 +: 10];
    cur_y  = bullet_y[int'(idx)*10 +: 10];
    cur_st = bullet_state[int'(idx)*2 +: 2];
    // 11-bit compares with offsets added to both sides, so nothing wraps near 0 or 1023
    in_box = ({1'b0, cur_x} + {1'b0, HALF_W} >= {1'b0, px_q}) &&
             ({1'b0, cur_x} <= {1'b0, px_q} + {1'b0, HALF_W}) &&
             ({1'b0, cur_y} + {1'b0, HALF_H} >= {1'b0, py_q}) &&
             ({1'b0, cur_y} <= {1'b0, py_q} + {1'b0, HALF_H});
    active    = (cur_st == 2'b01) || (cur_st == 2'b10);
    candidate = active && in_box;
    last      = (idx == IDXW'(N_BULLETS - 1));
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < N_BULLETS; i++)
      pop = pop + 5'(scratch[i]);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (frame_start) state_nxt = SCAN;
      end
      SCAN:    if (last) state_nxt = PUBLISH;
      PUBLISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      idx       <= '0;
      px_q      <= '0;
      py_q      <= '0;
      mask      <= '0;
      scratch   <= '0;
      hit       <= '0;
      hit_count <= '0;
      hit_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      hit_valid <= 1'b0;
      // PUBLISH counts as busy, so a request landing on the return to IDLE is dropped too
      if (frame_start && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (frame_start) begin
            px_q    <= player_x;
            py_q    <= player_y;
            idx     <= '0;
            scratch <= '0;
          end
        end
        SCAN: begin
          if (cur_st == 2'b00) begin
            mask[idx] <= 1'b0;
          end else if (candidate && !mask[idx]) begin
            mask[idx]    <= 1'b1;
            scratch[idx] <= 1'b1;
          end
          if (!last) idx <= idx + 1'b1;
        end
        PUBLISH: begin
          hit       <= scratch;
          hit_count <= pop;
          hit_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bullet_hit_scanner.sv
// Directed bench for bullet_hit_scanner: vector table of single-frame scans plus
// hand sequences for masking, overrun, reset mid-scan and latency.
module tb_bullet_hit_scanner;

  localparam int NB = 20;

  logic               Clk = 1'b0;
  logic               Reset_n = 1'b0;
  logic               frame_start = 1'b0;
  logic [9:0]         player_x = '0, player_y = '0;
  logic [10*NB-1:0]   bullet_x, bullet_y;
  logic [2*NB-1:0]    bullet_state;
  logic [NB-1:0]      hit;
  logic [4:0]         hit_count;
  logic               hit_valid, busy, overrun;

  logic [9:0] bxa [NB];
  logic [9:0] bya [NB];
  logic [1:0] bsa [NB];

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  always_comb begin
    bullet_x     = '0;
    bullet_y     = '0;
    bullet_state = '0;
    for (int i = 0; i < NB; i++) begin
      bullet_x[i*10 +: 10]   = bxa[i];
      bullet_y[i*10 +: 10]   = bya[i];
      bullet_state[i*2 +: 2] = bsa[i];
    end
  end

  bullet_hit_scanner #(.N_BULLETS(NB), .HALF_W(10'd16), .HALF_H(10'd16)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .frame_start  (frame_start),
    .player_x     (player_x),
    .player_y     (player_y),
    .bullet_x     (bullet_x),
    .bullet_y     (bullet_y),
    .bullet_state (bullet_state),
    .hit          (hit),
    .hit_count    (hit_count),
    .hit_valid    (hit_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  typedef struct {
    logic [9:0]  px, py;
    int          ia;
    logic [9:0]  ax, ay;
    logic [1:0]  sa;
    int          ib;
    logic [9:0]  bx, by;
    logic [1:0]  sb;
    logic [19:0] exp_hit;
    logic [4:0]  exp_cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic clear_all();
    for (int i = 0; i < NB; i++) begin
      bxa[i] = '0;
      bya[i] = '0;
      bsa[i] = 2'b00;
    end
  endtask

  task automatic set_bullet(input int i, input logic [9:0] x, input logic [9:0] y, input logic [1:0] s);
    bxa[i] = x;
    bya[i] = y;
    bsa[i] = s;
  endtask

  // armed: frame_start already raised by the caller before the next rising edge
  task automatic run_scan(input string nm, input logic [19:0] exp_hit, input logic [4:0] exp_cnt,
                          input int extra_fs, input bit disturb, input bit armed);
    int lat;
    lat = 0;
    if (!armed) begin
      @(negedge Clk);
      frame_start = 1'b1;
    end
    @(posedge Clk);
    #1 frame_start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (disturb && k == 2) begin
        player_x = 10'd900;
        player_y = 10'd900;
      end
      if (extra_fs != 0 && k == extra_fs) begin
        @(negedge Clk);
        frame_start = 1'b1;
        @(posedge Clk);
        #1 frame_start = 1'b0;
      end else begin
        @(posedge Clk);
        #1;
      end
      if (k == 1)  check({nm, " busy_scan"}, 32'(busy), 32'd1);
      if (k == 20) check({nm, " busy_publish"}, 32'(busy), 32'd1);
      if (hit_valid) begin
        lat = k;
        break;
      end
    end
    check({nm, " latency"}, 32'(lat), 32'd21);
    check({nm, " hit"}, 32'(hit), 32'(exp_hit));
    check({nm, " hit_count"}, 32'(hit_count), 32'(exp_cnt));
    @(posedge Clk);
    #1;
    check({nm, " valid_one_cycle"}, 32'(hit_valid), 32'd0);
    check({nm, " busy_idle"}, 32'(busy), 32'd0);
    check({nm, " hit_held"}, 32'(hit), 32'(exp_hit));
  endtask

  task automatic pulse_reset();
    @(negedge Clk);
    Reset_n = 1'b0;
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  initial begin
    int pulses;
    vecs[0] = '{10'd100, 10'd100,  3, 10'd116,  10'd84,   2'b01,  0, 10'd0,    10'd0,    2'b00, 20'h00008, 5'd1};
    vecs[1] = '{10'd100, 10'd100,  0, 10'd117,  10'd100,  2'b10,  1, 10'd100,  10'd83,   2'b10, 20'h00000, 5'd0};
    vecs[2] = '{10'd5,   10'd5,    7, 10'd0,    10'd0,    2'b01,  0, 10'd0,    10'd0,    2'b00, 20'h00080, 5'd1};
    vecs[3] = '{10'd200, 10'd200,  4, 10'd200,  10'd200,  2'b11,  0, 10'd0,    10'd0,    2'b00, 20'h00000, 5'd0};
    vecs[4] = '{10'd500, 10'd500, 19, 10'd484,  10'd516,  2'b10, 10, 10'd515,  10'd485,  2'b01, 20'h80400, 5'd2};
    vecs[5] = '{10'd1023,10'd1023,12, 10'd1023, 10'd1023, 2'b01, 13, 10'd1007, 10'd1007, 2'b10, 20'h03000, 5'd2};
    vecs[6] = '{10'd5,   10'd0,    2, 10'd1020, 10'd0,    2'b01,  9, 10'd0,    10'd1020, 2'b01, 20'h00000, 5'd0};
    vecs[7] = '{10'd300, 10'd300,  6, 10'd284,  10'd316,  2'b01, 11, 10'd283,  10'd300,  2'b01, 20'h00040, 5'd1};
    vecs[8] = '{10'd16,  10'd16,  15, 10'd0,    10'd32,   2'b10, 16, 10'd32,   10'd0,    2'b01, 20'h18000, 5'd2};

    clear_all();
    #1;
    check("reset hit", 32'(hit), 32'd0);
    check("reset hit_count", 32'(hit_count), 32'd0);
    check("reset hit_valid", 32'(hit_valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset overrun", 32'(overrun), 32'd0);

    // Release and request a scan on the very first edge after reset
    @(negedge Clk);
    Reset_n     = 1'b1;
    frame_start = 1'b1;
    run_scan("first_after_reset", 20'h0, 5'd0, 0, 1'b0, 1'b1);

    for (int v = 0; v < 9; v++) begin
      clear_all();
      player_x = vecs[v].px;
      player_y = vecs[v].py;
      set_bullet(vecs[v].ia, vecs[v].ax, vecs[v].ay, vecs[v].sa);
      set_bullet(vecs[v].ib, vecs[v].bx, vecs[v].by, vecs[v].sb);
      run_scan($sformatf("vec%0d", v), vecs[v].exp_hit, vecs[v].exp_cnt, 0, 1'b0, 1'b0);
      clear_all();
      run_scan($sformatf("vec%0d_clear", v), 20'h0, 5'd0, 0, 1'b0, 1'b0);
    end

    // Every slot hit at once
    clear_all();
    player_x = 10'd60;
    player_y = 10'd50;
    for (int i = 0; i < NB; i++) set_bullet(i, 10'd50, 10'd60, 2'b10);
    run_scan("all_hit", 20'hFFFFF, 5'd20, 0, 1'b0, 1'b0);
    clear_all();
    run_scan("all_hit_clear", 20'h0, 5'd0, 0, 1'b0, 1'b0);

    // Mask: one report per lifetime, re-armed by an idle frame
    player_x = 10'd400;
    player_y = 10'd400;
    set_bullet(5, 10'd410, 10'd390, 2'b01);
    run_scan("mask_f1", 20'h00020, 5'd1, 0, 1'b0, 1'b0);
    run_scan("mask_f2", 20'h0, 5'd0, 0, 1'b0, 1'b0);
    run_scan("mask_f3", 20'h0, 5'd0, 0, 1'b0, 1'b0);
    bsa[5] = 2'b00;
    run_scan("mask_idle", 20'h0, 5'd0, 0, 1'b0, 1'b0);
    bsa[5] = 2'b01;
    run_scan("mask_rearm", 20'h00020, 5'd1, 0, 1'b0, 1'b0);
    clear_all();
    run_scan("mask_clear", 20'h0, 5'd0, 0, 1'b0, 1'b0);

    // Player movement during a scan must not affect it
    player_x = 10'd100;
    player_y = 10'd100;
    set_bullet(3, 10'd116, 10'd84, 2'b01);
    run_scan("player_move", 20'h00008, 5'd1, 0, 1'b1, 1'b0);
    clear_all();
    run_scan("player_move_clear", 20'h0, 5'd0, 0, 1'b0, 1'b0);
    check("overrun_before", 32'(overrun), 32'd0);

    // Overrun: second request mid-scan ignored, flag sticky until reset
    player_x = 10'd100;
    player_y = 10'd100;
    set_bullet(1, 10'd100, 10'd100, 2'b01);
    run_scan("overrun_scan", 20'h00002, 5'd1, 10, 1'b0, 1'b0);
    check("overrun_set", 32'(overrun), 32'd1);
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge Clk);
      #1;
      if (hit_valid) pulses++;
    end
    check("overrun_no_extra_publish", 32'(pulses), 32'd0);
    check("overrun_sticky", 32'(overrun), 32'd1);
    pulse_reset();
    #1;
    check("overrun_cleared", 32'(overrun), 32'd0);

    // Request coinciding with PUBLISH -> IDLE is treated as busy
    clear_all();
    run_scan("publish_fs", 20'h0, 5'd0, 21, 1'b0, 1'b0);
    check("publish_fs_overrun", 32'(overrun), 32'd1);
    pulse_reset();

    // Reset mid-scan aborts with no publish; mask left clear
    clear_all();
    player_x = 10'd100;
    player_y = 10'd100;
    set_bullet(2, 10'd100, 10'd100, 2'b01);
    run_scan("pre_abort", 20'h00004, 5'd1, 0, 1'b0, 1'b0);
    bsa[2] = 2'b00;
    run_scan("pre_abort_clear", 20'h0, 5'd0, 0, 1'b0, 1'b0);
    bsa[2] = 2'b01;
    @(negedge Clk);
    frame_start = 1'b1;
    @(posedge Clk);
    #1 frame_start = 1'b0;
    repeat (11) @(posedge Clk);
    @(posedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    check("abort hit_valid", 32'(hit_valid), 32'd0);
    check("abort hit", 32'(hit), 32'd0);
    check("abort hit_count", 32'(hit_count), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    repeat (3) @(negedge Clk);
    Reset_n     = 1'b1;
    frame_start = 1'b1;
    run_scan("after_abort", 20'h00004, 5'd1, 0, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
